uart_tx: RTL
============

Name: uart_tx

Overview:
UART transmit block, the transmit counterpart of the UART Rx path. It accepts a parallel word with a one-cycle valid strobe and serialises it onto a single line, LSB first. The frame is start bit, WIDTH data bits, an optional parity bit, then a stop bit. CLK is the bit-rate clock, so each bit lasts exactly one CLK cycle. Internally it contains a frame FSM, a load/shift serialiser, a parity calculator and an output mux.

Parameters:
WIDTH, 8, data word width in bits (≥2)

Ports:
CLK  input  1  bit-rate clock; all state updates on the rising edge
RST  input  1  asynchronous active-low reset
P_DATA  input  WIDTH  parallel data to transmit
Data_Valid  input  1  P_DATA valid; sampled only in IDLE
PAR_EN  input  1  1 = parity bit included in the frame
PAR_TYP  input  1  0 = even parity, 1 = odd parity
TX_OUT  output  1  serial line, idle high; registered
Busy  output  1  high while a frame is on the line; registered

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous, active-low.
- Reset values: TX_OUT=1, Busy=0, state=IDLE, bit counter=0, data/parity/config registers=0. Reset takes effect immediately, including mid-frame; the partial frame is abandoned with no stop bit forced.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, Busy=0.
  - If Data_Valid=1 at a rising edge, latch P_DATA, PAR_EN and PAR_TYP, then go to START.
  - Inputs are ignored outside IDLE; later changes to P_DATA, PAR_EN or PAR_TYP do not affect the frame in flight.
- Latency: Data_Valid sampled at edge N; the start bit (TX_OUT=0) and Busy=1 appear after edge N.
- START: TX_OUT=0 for one cycle, then DATA with counter=0.
- DATA:
  - TX_OUT = latched bit[counter], LSB first. The shift-register implementation is equivalent: shift right, output bit 0.
  - Counter increments each cycle.
  - After bit WIDTH-1, go to PARITY if latched PAR_EN=1, otherwise to STOP.
- PARITY:
  - Parity bit = XOR-reduce of latched data, XOR latched PAR_TYP.
  - Even parity makes the total count of ones (data+parity) even; odd parity makes it odd.
  - The parity bit is computed from the latched word, not the live P_DATA. One cycle, then STOP.
- STOP: TX_OUT=1 for one cycle, then IDLE.
- Busy: 1 in START, DATA, PARITY and STOP; 0 in IDLE. It deasserts on the edge that leaves STOP.
- Frame length: 2+WIDTH+PAR_EN cycles (11 with parity, 10 without, for WIDTH=8).
- Back-to-back: the earliest next acceptance is the first IDLE cycle. If Data_Valid is held high continuously, frames are separated by exactly one IDLE cycle with TX_OUT=1.
- Data_Valid asserted during Busy is dropped. It is not queued.
- TX_OUT is glitch-free: driven directly from a flop, never from combinational muxing.
- Counter width: clog2(WIDTH). The counter never wraps inside a frame and is cleared on entering DATA.

Test Plan:
1. Reset, then hold idle 5 cycles -> TX_OUT=1, Busy=0 throughout.
2. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles. Busy=1 for exactly those 11 cycles. Even parity bit=0.
3. Same frame with PAR_TYP=1 -> parity bit=1; other bits unchanged. Then P_DATA=0x07, PAR_EN=0 -> 0,1,1,1,0,0,0,0,0,1 over 10 cycles with no parity slot.
4. Pulse Data_Valid with P_DATA=0xFF at cycle 3 of a 0x00 frame, and change P_DATA and PAR_TYP mid-frame -> the in-flight frame is bit-exact 0x00 with its original parity. The 0xFF request is dropped and no second frame is sent.
5. Data_Valid held high with P_DATA=0x3C, PAR_EN=1, PAR_TYP=0 -> repeated 11-cycle frames with exactly one TX_OUT=1 idle cycle between them, and Busy low in that cycle.
6. Assert RST low asynchronously (between edges) during the DATA state of 0x55 -> TX_OUT=1 and Busy=0 immediately. After release, no residual bits are sent, and a new 0x81 frame transmits correctly.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Serialises a latched word as start, WIDTH data
// bits (LSB first), optional parity and stop, one bit per CLK cycle.
`default_nettype none

module uart_tx #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic             TX_OUT,
  output logic             Busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] next_idx;
  logic [WIDTH-1:0] data_reg;
  logic             par_en_reg;
  logic             par_typ_reg;
  logic             parity_bit;

  assign next_idx   = bit_cnt + 1'b1;
  assign parity_bit = (^data_reg) ^ par_typ_reg;

  // TX_OUT and Busy are loaded with the value belonging to the state being
  // entered, so both come straight from flops with no output decode.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
      TX_OUT      <= 1'b1;
      Busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
          if (Data_Valid) begin
            data_reg    <= P_DATA;
            par_en_reg  <= PAR_EN;
            par_typ_reg <= PAR_TYP;
            state       <= START;
            TX_OUT      <= 1'b0;
            Busy        <= 1'b1;
          end
        end
        START: begin
          state   <= DATA;
          bit_cnt <= '0;
          TX_OUT  <= data_reg[0];
          Busy    <= 1'b1;
        end
        DATA: begin
          Busy    <= 1'b1;
          bit_cnt <= next_idx;
          if (bit_cnt == LAST_BIT) begin
            if (par_en_reg) begin
              state  <= PARITY;
              TX_OUT <= parity_bit;
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
            end
          end else begin
            TX_OUT <= data_reg[next_idx];
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
          Busy   <= 1'b1;
        end
        STOP: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
